recfn_cvt_arbiter: RTL and testbench
====================================

// Module: recfn_cvt_arbiter
// PURPOSE
//  Shares one combinational recoded-single -> recoded-double converter (33b -> 65b) among
//  NUM_REQ requesters. Round-robin arbitration, valid/ready handshakes, one-entry registered
//  response buffer. Sits between FPU issue ports and the shared conversion datapath.
// PARAMETERS
//  NUM_REQ  4  number of requesters (2..8)
//  TAG_W    5  width of per-request tag returned with the response
//  SRC_W    2  width of resp_src (= clog2(NUM_REQ))
// PORTS
//  clk         in   1            clock
//  reset_n     in   1            asynchronous active-low reset
//  req_valid   in   NUM_REQ      request valid, one bit per requester
//  req_ready   out  NUM_REQ      request accepted this cycle (one-hot or zero)
//  req_in      in   NUM_REQ*33   recoded single operands, requester i at [33*i +: 33]
//  req_rm      in   NUM_REQ*2    rounding modes, requester i at [2*i +: 2]
//  req_tag     in   NUM_REQ*TAG_W  tags, requester i at [TAG_W*i +: TAG_W]
//  cvt_in      out  33           operand to shared converter
//  cvt_rm      out  2            rounding mode to shared converter
//  cvt_out     in   65           converter result (combinational from cvt_in)
//  cvt_flags   in   5            converter exception flags {NV,DZ,OF,UF,NX}
//  resp_valid  out  1            response buffer holds a result
//  resp_ready  in   1            consumer takes response
//  resp_out    out  65           recoded double result
//  resp_flags  out  5            exception flags of that result
//  resp_tag    out  TAG_W        tag of the granted request
//  resp_src    out  SRC_W        index of the granted requester
//  fflags_clr  in   1            clear accumulated flags (feature only)
//  fflags_acc  out  5            sticky OR of delivered flags (feature only)
// BEHAVIOUR
//  Reset: resp_valid=0, resp_out/flags/tag/src=0, rr_ptr=0, fflags_acc=0; req_ready=0 while in reset.
//  States: EMPTY (resp_valid=0), FULL (resp_valid=1). can_issue = EMPTY | (FULL & resp_ready).
//  Grant: if can_issue and any req_valid, pick first set bit scanning from rr_ptr upward, wrap
//   modulo NUM_REQ; assert req_ready[g] only (combinational, same cycle). No request -> all 0.
//  Datapath: cvt_in/cvt_rm muxed from granted requester; when nothing is granted they carry
//   the last granted requester's operand (no glitch requirement). Result + flags + tag + src
//   registered on the grant edge -> latency 1 cycle, throughput 1 per cycle.
//  Transitions: EMPTY+grant->FULL; FULL+resp_ready+grant->FULL (new data);
//   FULL+resp_ready+no grant->EMPTY; FULL+!resp_ready->FULL, outputs held stable.
//  rr_ptr <= (g+1) mod NUM_REQ on grant only; unchanged otherwise.
//  req_valid deasserted without ready: legal, no state change. Requester must hold operands stable while valid.
//  Reset mid-operation: buffered response dropped, no handshake completes in that cycle.
// CONFIGURATION
//  RECFN_CVT_STICKY_FLAGS_EN defined: fflags_acc <= (fflags_clr ? 0 : fflags_acc) |
//   (resp_valid & resp_ready ? resp_flags : 0); clear and set same cycle -> new flags kept.
//  Undefined: fflags_clr ignored, fflags_acc tied to 5'b0, no flag register.
// TESTING
//  (Bench drives cvt_* through the team's existing recoded single->double converter.)
//  1 req0 valid, req_in=33'h0_8000_0000 (1.0), tag=3, resp_ready=1 -> next cycle resp_valid=1,
//    resp_out=65'h0_8000_0000_0000_0000, flags=0, tag=3, src=0.
//  2 req0 sNaN 33'h0_E000_0001 -> resp_out=65'h0_E008_0000_0000_0000, resp_flags=5'h10.
//  3 all 4 requesters valid continuously, resp_ready=1 -> grants 0,1,2,3,0 on successive cycles.
//  4 resp_ready=0 for 3 cycles with FULL buffer and req1 valid -> req_ready=0, outputs stable;
//    resp_ready=1 -> req1 granted same cycle, its result next cycle.
//  5 reset_n low while FULL -> resp_valid=0 immediately (async), rr_ptr=0 after release.
//  6 STICKY_FLAGS_EN: deliver sNaN then 1.0 -> fflags_acc=5'h10; fflags_clr pulse -> 5'h00.

Source files
------------

// File: rtl/recfn_cvt_arbiter.sv
// Round-robin arbiter sharing one recoded single->double converter among NUM_REQ requesters.
// Optional sticky exception-flag accumulator enabled by defining RECFN_CVT_STICKY_FLAGS_EN.
module recfn_cvt_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int TAG_W   = 5,
  parameter int SRC_W   = 2
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic [NUM_REQ-1:0]       req_valid,
  output logic [NUM_REQ-1:0]       req_ready,
  input  logic [NUM_REQ*33-1:0]    req_in,
  input  logic [NUM_REQ*2-1:0]     req_rm,
  input  logic [NUM_REQ*TAG_W-1:0] req_tag,
  output logic [32:0]              cvt_in,
  output logic [1:0]               cvt_rm,
  input  logic [64:0]              cvt_out,
  input  logic [4:0]               cvt_flags,
  output logic                     resp_valid,
  input  logic                     resp_ready,
  output logic [64:0]              resp_out,
  output logic [4:0]               resp_flags,
  output logic [TAG_W-1:0]         resp_tag,
  output logic [SRC_W-1:0]         resp_src,
  input  logic                     fflags_clr,
  output logic [4:0]               fflags_acc
);

  localparam logic [0:0] ST_EMPTY = 1'b0;
  localparam logic [0:0] ST_FULL  = 1'b1;

  logic [0:0]       state_r;
  logic [0:0]       state_nx_s;
  logic [SRC_W-1:0] rr_ptr_r;
  logic [SRC_W-1:0] rr_nx_s;
  logic [SRC_W-1:0] cand_s;
  logic [SRC_W-1:0] grant_idx_s;
  logic [SRC_W-1:0] sel_s;
  logic             grant_any_s;
  logic             can_issue_s;
  logic             issue_s;
  logic [64:0]      resp_out_r;
  logic [4:0]       resp_flags_r;
  logic [TAG_W-1:0] resp_tag_r;
  logic [SRC_W-1:0] resp_src_r;

  assign resp_valid  = (state_r == ST_FULL);
  assign can_issue_s = (state_r == ST_EMPTY) || resp_ready;
  assign issue_s     = grant_any_s && can_issue_s && reset_n;

  // Round-robin search: first valid requester at or after rr_ptr, wrapping.
  always_comb begin
    grant_any_s = 1'b0;
    grant_idx_s = {SRC_W{1'b0}};
    cand_s      = {SRC_W{1'b0}};
    for (int k = 0; k < NUM_REQ; k++) begin
      cand_s = SRC_W'((int'(rr_ptr_r) + k) % NUM_REQ);
      if (!grant_any_s && req_valid[cand_s]) begin
        grant_any_s = 1'b1;
        grant_idx_s = cand_s;
      end else begin
        grant_idx_s = grant_idx_s;
      end
    end
  end

  // One-hot ready toward the granted requester only.
  always_comb begin
    req_ready = {NUM_REQ{1'b0}};
    if (issue_s) begin
      req_ready[grant_idx_s] = 1'b1;
    end else begin
      req_ready = {NUM_REQ{1'b0}};
    end
  end

  // Idle converter input keeps the last granted operand to avoid needless toggling.
  assign sel_s   = issue_s ? grant_idx_s : resp_src_r;
  assign cvt_in  = req_in[33*sel_s +: 33];
  assign cvt_rm  = req_rm[2*sel_s +: 2];
  assign rr_nx_s = (grant_idx_s == SRC_W'(NUM_REQ - 1)) ? {SRC_W{1'b0}} : grant_idx_s + SRC_W'(1);

  // Response-buffer next state.
  always_comb begin
    state_nx_s = state_r;
    case (state_r)
      ST_EMPTY: state_nx_s = issue_s ? ST_FULL : ST_EMPTY;
      ST_FULL:  state_nx_s = (issue_s || !resp_ready) ? ST_FULL : ST_EMPTY;
      default:  state_nx_s = ST_EMPTY;
    endcase
  end

  // Response buffer and round-robin pointer; loads only on an issued grant.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r      <= ST_EMPTY;
      rr_ptr_r     <= {SRC_W{1'b0}};
      resp_out_r   <= 65'h0;
      resp_flags_r <= 5'h0;
      resp_tag_r   <= {TAG_W{1'b0}};
      resp_src_r   <= {SRC_W{1'b0}};
    end else begin
      state_r <= state_nx_s;
      if (issue_s) begin
        rr_ptr_r     <= rr_nx_s;
        resp_out_r   <= cvt_out;
        resp_flags_r <= cvt_flags;
        resp_tag_r   <= req_tag[TAG_W*grant_idx_s +: TAG_W];
        resp_src_r   <= grant_idx_s;
      end
    end
  end

  assign resp_out   = resp_out_r;
  assign resp_flags = resp_flags_r;
  assign resp_tag   = resp_tag_r;
  assign resp_src   = resp_src_r;

`ifdef RECFN_CVT_STICKY_FLAGS_EN
  logic [4:0] fflags_acc_r;

  // Sticky OR of delivered flags; a same-cycle delivery survives a clear.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      fflags_acc_r <= 5'h0;
    end else begin
      fflags_acc_r <= (fflags_clr ? 5'h0 : fflags_acc_r) |
                      ((resp_valid && resp_ready) ? resp_flags_r : 5'h0);
    end
  end

  assign fflags_acc = fflags_acc_r;
`else
  logic unused_fflags_clr_s;
  assign unused_fflags_clr_s = fflags_clr;
  assign fflags_acc          = 5'h0;
`endif

endmodule

// File: tb/tb_recfn_cvt_arbiter.sv
// Directed self-checking bench for recfn_cvt_arbiter with a behavioural recoded
// single->double converter on the cvt_* port.
module tb_recfn_cvt_arbiter;
  localparam int NUM_REQ = 4;
  localparam int TAG_W   = 5;
  localparam int SRC_W   = 2;

  logic                     clk = 1'b0;
  logic                     reset_n = 1'b1;
  logic [NUM_REQ-1:0]       req_valid = '0;
  logic [NUM_REQ-1:0]       req_ready;
  logic [NUM_REQ*33-1:0]    req_in = '0;
  logic [NUM_REQ*2-1:0]     req_rm = '0;
  logic [NUM_REQ*TAG_W-1:0] req_tag = '0;
  logic [32:0]              cvt_in;
  logic [1:0]               cvt_rm;
  logic [64:0]              cvt_out;
  logic [4:0]               cvt_flags;
  logic                     resp_valid;
  logic                     resp_ready = 1'b0;
  logic [64:0]              resp_out;
  logic [4:0]               resp_flags;
  logic [TAG_W-1:0]         resp_tag;
  logic [SRC_W-1:0]         resp_src;
  logic                     fflags_clr = 1'b0;
  logic [4:0]               fflags_acc;

  int checks = 0;
  int errors = 0;

  recfn_cvt_arbiter #(.NUM_REQ(NUM_REQ), .TAG_W(TAG_W), .SRC_W(SRC_W)) dut (
    .clk(clk), .reset_n(reset_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_in(req_in), .req_rm(req_rm), .req_tag(req_tag),
    .cvt_in(cvt_in), .cvt_rm(cvt_rm), .cvt_out(cvt_out), .cvt_flags(cvt_flags),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_out(resp_out), .resp_flags(resp_flags),
    .resp_tag(resp_tag), .resp_src(resp_src), .fflags_clr(fflags_clr), .fflags_acc(fflags_acc)
  );

  always #5 clk = ~clk;

  // Recoded single -> recoded double: rebias exponent, widen significand, canonical NaN.
  function automatic logic [69:0] cvt_model(input logic [32:0] a);
    logic [69:0] r;
    case (a[31:29])
      3'b000:  r = {a[32], 64'h0, 5'h00};
      3'b110:  r = {a[32], 12'hC00, 52'h0, 5'h00};
      3'b111:  r = {1'b0, 12'hE00, 1'b1, 51'h0, (a[22] ? 5'h00 : 5'h10)};
      default: r = {a[32], 12'(a[31:23]) + 12'h700, a[22:0], 29'h0, 5'h00};
    endcase
    return r;
  endfunction

  always_comb {cvt_out, cvt_flags} = cvt_model(cvt_in);

  function automatic logic [32:0] one_in(input int i);
    return 33'h0_8000_0000 | 33'(i);
  endfunction

  function automatic logic [64:0] one_out(input int i);
    return {1'b0, 12'h800, 23'(i), 29'h0};
  endfunction

  task automatic set_req(input int i, input logic [32:0] val, input logic [TAG_W-1:0] tag);
    req_in[33*i +: 33]       = val;
    req_tag[TAG_W*i +: TAG_W] = tag;
  endtask

  task automatic test_reset();
    for (int i = 0; i < NUM_REQ; i++) set_req(i, one_in(i), 5'(i + 8));
    reset_n = 1'b0; req_valid = 4'hF; resp_ready = 1'b1;
    @(posedge clk); #1;
    checks++; if (resp_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %0h want 0", resp_valid); end
    checks++; if (req_ready !== 4'h0) begin errors++; $display("FAIL reset_ready got %0h want 0", req_ready); end
    checks++; if (resp_out !== 65'h0) begin errors++; $display("FAIL reset_out got %0h want 0", resp_out); end
    checks++; if ({resp_flags, resp_tag, resp_src} !== 12'h0) begin errors++; $display("FAIL reset_fields got %0h/%0h/%0h want 0", resp_flags, resp_tag, resp_src); end
    checks++; if (fflags_acc !== 5'h0) begin errors++; $display("FAIL reset_acc got %0h want 0", fflags_acc); end
    @(negedge clk); reset_n = 1'b1; req_valid = 4'h0;
  endtask

  task automatic test_round_robin();
    @(negedge clk); req_valid = 4'hF; resp_ready = 1'b1;
    for (int c = 0; c < 5; c++) begin
      #1;
      checks++; if (req_ready !== 4'(1 << (c % 4))) begin errors++; $display("FAIL rr_ready[%0d] got %0h want %0h", c, req_ready, 4'(1 << (c % 4))); end
      @(posedge clk); #1;
      checks++; if (resp_valid !== 1'b1 || resp_src !== 2'(c % 4) || resp_tag !== 5'(c % 4 + 8))
        begin errors++; $display("FAIL rr_resp[%0d] got v%0h s%0h t%0h want v1 s%0h t%0h", c, resp_valid, resp_src, resp_tag, c % 4, c % 4 + 8); end
      checks++; if (resp_out !== one_out(c % 4)) begin errors++; $display("FAIL rr_out[%0d] got %0h want %0h", c, resp_out, one_out(c % 4)); end
      @(negedge clk);
    end
    req_valid = 4'h0;
    @(posedge clk); #1;
    checks++; if (resp_valid !== 1'b0) begin errors++; $display("FAIL rr_drain got %0h want 0", resp_valid); end
    @(negedge clk);
  endtask

  task automatic test_single(input logic [32:0] op, input logic [64:0] exp_out, input logic [4:0] exp_flags, input logic [4:0] tag);
    set_req(0, op, tag);
    @(negedge clk); req_valid = 4'h1; resp_ready = 1'b1;
    #1;
    checks++; if (req_ready !== 4'h1 || cvt_in !== op) begin errors++; $display("FAIL single_issue got r%0h in%0h want r1 in%0h", req_ready, cvt_in, op); end
    @(posedge clk); #1;
    checks++; if (resp_valid !== 1'b1 || resp_out !== exp_out) begin errors++; $display("FAIL single_out got v%0h %0h want v1 %0h", resp_valid, resp_out, exp_out); end
    checks++; if (resp_flags !== exp_flags || resp_tag !== tag || resp_src !== 2'd0)
      begin errors++; $display("FAIL single_meta got f%0h t%0h s%0h want f%0h t%0h s0", resp_flags, resp_tag, resp_src, exp_flags, tag); end
    @(negedge clk); req_valid = 4'h0;
    @(posedge clk); #1;
    checks++; if (resp_valid !== 1'b0) begin errors++; $display("FAIL single_drain got %0h want 0", resp_valid); end
    @(negedge clk);
  endtask

  task automatic test_backpressure();
    set_req(0, one_in(0), 5'd6); set_req(1, one_in(1), 5'd7);
    @(negedge clk); req_valid = 4'h1; resp_ready = 1'b0;
    @(posedge clk); #1;
    checks++; if (resp_valid !== 1'b1 || resp_src !== 2'd0) begin errors++; $display("FAIL bp_fill got v%0h s%0h want v1 s0", resp_valid, resp_src); end
    @(negedge clk); req_valid = 4'h2;
    for (int c = 0; c < 3; c++) begin
      #1;
      checks++; if (req_ready !== 4'h0) begin errors++; $display("FAIL bp_ready[%0d] got %0h want 0", c, req_ready); end
      @(posedge clk); #1;
      checks++; if (resp_valid !== 1'b1 || resp_src !== 2'd0 || resp_tag !== 5'd6 || resp_out !== one_out(0))
        begin errors++; $display("FAIL bp_hold[%0d] got v%0h s%0h t%0h %0h", c, resp_valid, resp_src, resp_tag, resp_out); end
      @(negedge clk);
    end
    resp_ready = 1'b1;
    #1;
    checks++; if (req_ready !== 4'h2) begin errors++; $display("FAIL bp_release got %0h want 2", req_ready); end
    @(posedge clk); #1;
    checks++; if (resp_src !== 2'd1 || resp_tag !== 5'd7 || resp_out !== one_out(1))
      begin errors++; $display("FAIL bp_next got s%0h t%0h %0h want s1 t7 %0h", resp_src, resp_tag, resp_out, one_out(1)); end
    @(negedge clk); req_valid = 4'h0;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic test_async_reset();
    set_req(2, one_in(2), 5'd9);
    @(negedge clk); req_valid = 4'h4; resp_ready = 1'b0;
    @(posedge clk); #1;
    checks++; if (resp_valid !== 1'b1 || resp_src !== 2'd2) begin errors++; $display("FAIL ar_fill got v%0h s%0h want v1 s2", resp_valid, resp_src); end
    @(negedge clk); #2; reset_n = 1'b0; #1;
    checks++; if (resp_valid !== 1'b0 || req_ready !== 4'h0 || resp_src !== 2'd0)
      begin errors++; $display("FAIL ar_async got v%0h r%0h s%0h want 0 0 0", resp_valid, req_ready, resp_src); end
    @(posedge clk);
    @(negedge clk); reset_n = 1'b1; req_valid = 4'h9; resp_ready = 1'b1;
    #1;
    checks++; if (req_ready !== 4'h1) begin errors++; $display("FAIL ar_ptr got %0h want 1", req_ready); end
    @(posedge clk); #1;
    checks++; if (resp_src !== 2'd0) begin errors++; $display("FAIL ar_src got %0h want 0", resp_src); end
    @(negedge clk); req_valid = 4'h0;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic test_sticky();
    logic [4:0] exp_acc;
`ifdef RECFN_CVT_STICKY_FLAGS_EN
    exp_acc = 5'h10;
`else
    exp_acc = 5'h00;
`endif
    set_req(0, 33'h0_E000_0001, 5'd1);
    @(negedge clk); req_valid = 4'h1; resp_ready = 1'b1;
    @(posedge clk);
    @(negedge clk); set_req(0, one_in(0), 5'd2);
    @(posedge clk);
    @(negedge clk); req_valid = 4'h0;
    @(posedge clk); #1;
    checks++; if (fflags_acc !== exp_acc) begin errors++; $display("FAIL sticky_acc got %0h want %0h", fflags_acc, exp_acc); end
    @(negedge clk); fflags_clr = 1'b1;
    @(posedge clk); #1;
    checks++; if (fflags_acc !== 5'h0) begin errors++; $display("FAIL sticky_clr got %0h want 0", fflags_acc); end
    @(negedge clk); fflags_clr = 1'b0; set_req(0, 33'h0_E000_0001, 5'd3); req_valid = 4'h1;
    @(posedge clk);
    @(negedge clk); req_valid = 4'h0; fflags_clr = 1'b1;
    @(posedge clk); #1;
    checks++; if (fflags_acc !== exp_acc) begin errors++; $display("FAIL sticky_clr_set got %0h want %0h", fflags_acc, exp_acc); end
    @(negedge clk); fflags_clr = 1'b0;
  endtask

  initial begin
    test_reset();
    test_round_robin();
    test_single(33'h0_8000_0000, 65'h0_8000_0000_0000_0000, 5'h00, 5'd3);
    test_single(33'h0_E000_0001, 65'h0_E008_0000_0000_0000, 5'h10, 5'd4);
    test_backpressure();
    test_async_reset();
    test_sticky();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

endmodule
